// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: glyphs, conversion FSM states,
// digit indices, anode patterns and the double-dabble nibble adjust helper.
package seg7_pkg;

  localparam int unsigned BIN_W  = 8;
  localparam int unsigned BCD_W  = 12;
  localparam int unsigned PAIR_W = 10;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] GLYPH_0     = 7'b1000000;
  localparam logic [6:0] GLYPH_1     = 7'b1111001;
  localparam logic [6:0] GLYPH_2     = 7'b0100100;
  localparam logic [6:0] GLYPH_3     = 7'b0110000;
  localparam logic [6:0] GLYPH_4     = 7'b0011001;
  localparam logic [6:0] GLYPH_5     = 7'b0010010;
  localparam logic [6:0] GLYPH_6     = 7'b0000010;
  localparam logic [6:0] GLYPH_7     = 7'b1111000;
  localparam logic [6:0] GLYPH_8     = 7'b0000000;
  localparam logic [6:0] GLYPH_9     = 7'b0010000;
  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    CONV_IDLE  = 2'd0,
    CONV_SHIFT = 2'd1,
    CONV_DONE  = 2'd2
  } conv_state_e;

  localparam logic [1:0] DIG_UNITS = 2'd0;
  localparam logic [1:0] DIG_TENS  = 2'd1;
  localparam logic [1:0] DIG_HUND  = 2'd2;
  localparam logic [1:0] DIG_STATE = 2'd3;

  localparam logic [3:0] AN_UNITS = 4'b1110;
  localparam logic [3:0] AN_TENS  = 4'b1101;
  localparam logic [3:0] AN_HUND  = 4'b1011;
  localparam logic [3:0] AN_STATE = 4'b0111;
  localparam logic [3:0] AN_OFF   = 4'b1111;

  function automatic logic [6:0] glyph_of(input logic [3:0] digit);
    logic [6:0] g;
    case (digit)
      4'd0:    g = GLYPH_0;
      4'd1:    g = GLYPH_1;
      4'd2:    g = GLYPH_2;
      4'd3:    g = GLYPH_3;
      4'd4:    g = GLYPH_4;
      4'd5:    g = GLYPH_5;
      4'd6:    g = GLYPH_6;
      4'd7:    g = GLYPH_7;
      4'd8:    g = GLYPH_8;
      4'd9:    g = GLYPH_9;
      default: g = GLYPH_BLANK;
    endcase
    return g;
  endfunction

  function automatic logic [3:0] anode_of(input logic [1:0] idx);
    logic [3:0] an;
    case (idx)
      DIG_UNITS: an = AN_UNITS;
      DIG_TENS:  an = AN_TENS;
      DIG_HUND:  an = AN_HUND;
      DIG_STATE: an = AN_STATE;
      default:   an = AN_OFF;
    endcase
    return an;
  endfunction

  // Add 3 to every BCD nibble that is 5 or more, ahead of the next left shift
  function automatic logic [11:0] dabble_adjust(input logic [11:0] bcd);
    logic [11:0] res;
    res = 12'd0;
    for (int i = 0; i < 3; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) begin
        res[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
      end else begin
        res[i*4 +: 4] = bcd[i*4 +: 4];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_bin2bcd_seq.sv
// Sequential double-dabble converter: 8-bit binary to three BCD digits,
// one shift per clock, with a start/busy/done handshake.
module bin2bcd_seq
  import seg7_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [BIN_W-1:0]    bin_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [BCD_W-1:0]    bcd_o
);

  conv_state_e      state_r;
  conv_state_e      state_nxt_s;
  logic [2:0]       iter_r;
  logic [BIN_W-1:0] bin_r;
  logic [BCD_W-1:0] bcd_r;
  logic [BCD_W-1:0] bcd_adj_s;
  logic [BCD_W-1:0] bcd_nxt_s;
  logic [BIN_W-1:0] bin_nxt_s;

  // Conversion FSM state register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r <= CONV_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Conversion FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      CONV_IDLE: begin
        if (start_i) begin
          state_nxt_s = CONV_SHIFT;
        end else begin
          state_nxt_s = CONV_IDLE;
        end
      end
      CONV_SHIFT: begin
        if (iter_r == 3'd7) begin
          state_nxt_s = CONV_DONE;
        end else begin
          state_nxt_s = CONV_SHIFT;
        end
      end
      CONV_DONE: state_nxt_s = CONV_IDLE;
      default:   state_nxt_s = CONV_IDLE;
    endcase
  end

  // Conversion FSM handshake outputs
  always_comb begin
    busy_o = 1'b0;
    done_o = 1'b0;
    case (state_r)
      CONV_IDLE:  busy_o = 1'b0;
      CONV_SHIFT: busy_o = 1'b1;
      CONV_DONE: begin
        busy_o = 1'b1;
        done_o = 1'b1;
      end
      default: busy_o = 1'b0;
    endcase
  end

  assign bcd_adj_s              = dabble_adjust(bcd_r);
  assign {bcd_nxt_s, bin_nxt_s} = {bcd_adj_s[BCD_W-2:0], bin_r, 1'b0};
  assign bcd_o                  = bcd_r;

  // Shift register and iteration counter datapath
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      iter_r <= 3'd0;
      bin_r  <= 8'd0;
      bcd_r  <= 12'd0;
    end else begin
      case (state_r)
        CONV_IDLE: begin
          if (start_i) begin
            iter_r <= 3'd0;
            bin_r  <= bin_i;
            bcd_r  <= 12'd0;
          end
        end
        CONV_SHIFT: begin
          iter_r <= iter_r + 3'd1;
          bin_r  <= bin_nxt_s;
          bcd_r  <= bcd_nxt_s;
        end
        default: iter_r <= iter_r;
      endcase
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// 4-digit common-anode scan driver: value in decimal on digits 0-2, state on digit 3.
// Optional macro SEG7_LEADING_ZERO_BLANK_EN blanks leading zeros of the value.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned NUM_DIGITS  = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] value_i,
  input  logic [1:0] state_i,
  output logic [6:0] seg_o,
  output logic       dp_o,
  output logic [3:0] an_o
);

  localparam int unsigned         PRESC_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(REFRESH_DIV - 1);
  localparam logic [1:0]          LAST_DIG   = 2'(NUM_DIGITS - 1);

  logic [PAIR_W-1:0] sync1_r;
  logic [PAIR_W-1:0] sync2_r;
  logic [PAIR_W-1:0] cap_r;
  logic [BCD_W-1:0]  disp_bcd_r;
  logic [1:0]        disp_state_r;
  logic              stable_s;
  logic              start_s;
  logic              conv_busy_s;
  logic              conv_done_s;
  logic [BCD_W-1:0]  conv_bcd_s;

  logic [PRESC_W-1:0] presc_r;
  logic [1:0]         dig_idx_r;
  logic [1:0]         dig_idx_nxt_s;
  logic               scan_en_r;
  logic               scan_en_nxt_s;
  logic               scan_tick_s;

  logic [3:0] digit_s;
  logic       blank_s;
  logic       dp_nxt_s;
  logic [6:0] seg_nxt_s;
  logic [3:0] an_nxt_s;

  // A pair that differs between the two sync stages is still settling
  assign stable_s = (sync1_r == sync2_r);
  assign start_s  = !conv_busy_s && stable_s && (sync2_r != cap_r);

  // Input synchroniser, capture register and display registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sync1_r      <= 10'd0;
      sync2_r      <= 10'd0;
      cap_r        <= 10'd0;
      disp_bcd_r   <= 12'd0;
      disp_state_r <= 2'd0;
    end else begin
      sync1_r <= {state_i, value_i};
      sync2_r <= sync1_r;
      if (start_s) begin
        cap_r <= sync2_r;
      end
      if (conv_done_s) begin
        disp_bcd_r   <= conv_bcd_s;
        disp_state_r <= cap_r[9:8];
      end
    end
  end

  bin2bcd_seq u_bin2bcd (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_s),
    .bin_i   (sync2_r[7:0]),
    .busy_o  (conv_busy_s),
    .done_o  (conv_done_s),
    .bcd_o   (conv_bcd_s)
  );

  // Scan sequencing: the first tick only enables digit 0, later ticks advance
  always_comb begin
    scan_tick_s   = (presc_r == PRESC_LAST);
    dig_idx_nxt_s = dig_idx_r;
    scan_en_nxt_s = scan_en_r;
    if (scan_tick_s) begin
      if (!scan_en_r) begin
        scan_en_nxt_s = 1'b1;
      end else if (dig_idx_r == LAST_DIG) begin
        dig_idx_nxt_s = 2'd0;
      end else begin
        dig_idx_nxt_s = dig_idx_r + 2'd1;
      end
    end else begin
      dig_idx_nxt_s = dig_idx_r;
    end
  end

  // Digit select, blanking and glyph decode for the slot about to be shown
  always_comb begin
    digit_s  = 4'd0;
    blank_s  = 1'b0;
    dp_nxt_s = 1'b1;
    case (dig_idx_nxt_s)
      DIG_UNITS: digit_s = disp_bcd_r[3:0];
      DIG_TENS: begin
        digit_s = disp_bcd_r[7:4];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        blank_s = (disp_bcd_r[11:4] == 8'd0);
`else
        blank_s = 1'b0;
`endif
      end
      DIG_HUND: begin
        digit_s = disp_bcd_r[11:8];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        blank_s = (disp_bcd_r[11:8] == 4'd0);
`else
        blank_s = 1'b0;
`endif
      end
      DIG_STATE: begin
        digit_s  = {2'b00, disp_state_r};
        dp_nxt_s = 1'b0;
      end
      default: digit_s = 4'd0;
    endcase

    if (!scan_en_nxt_s) begin
      an_nxt_s  = AN_OFF;
      seg_nxt_s = GLYPH_BLANK;
      dp_nxt_s  = 1'b1;
    end else if (blank_s) begin
      an_nxt_s  = anode_of(dig_idx_nxt_s);
      seg_nxt_s = GLYPH_BLANK;
    end else begin
      an_nxt_s  = anode_of(dig_idx_nxt_s);
      seg_nxt_s = glyph_of(digit_s);
    end
  end

  // Prescaler, digit index and registered display outputs
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      presc_r   <= '0;
      dig_idx_r <= 2'd0;
      scan_en_r <= 1'b0;
      seg_o     <= 7'h7F;
      dp_o      <= 1'b1;
      an_o      <= 4'b1111;
    end else begin
      if (scan_tick_s) begin
        presc_r <= '0;
      end else begin
        presc_r <= presc_r + {{(PRESC_W-1){1'b0}}, 1'b1};
      end
      dig_idx_r <= dig_idx_nxt_s;
      scan_en_r <= scan_en_nxt_s;
      seg_o     <= seg_nxt_s;
      dp_o      <= dp_nxt_s;
      an_o      <= an_nxt_s;
    end
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Downstream display stage for the counter FSM. It takes the 8-bit indication value and the 2-bit state code, which change at 4 Hz, and samples them in the fast system clock domain. A sequential double-dabble engine converts the value to three BCD digits. The block then time-multiplexes a 4-digit common-anode 7-segment display: digits 0-2 show the value in decimal, digit 3 shows the state code.

Parameters:
REFRESH_DIV, 50000, system clocks per digit slot; must be >= 2 (1 kHz slot rate at 50 MHz; benches use 4).
NUM_DIGITS, 4, number of scanned digits; fixed at 4, kept for readability.

Ports:
clk_i  input  1  system clock (e.g. 50 MHz)
rst_i  input  1  reset, asynchronous, active-low
value_i  input  8  binary value to display (from counter FSM indication output)
state_i  input  2  FSM state code to display on digit 3
seg_o  output  7  segments {g,f,e,d,c,b,a}, active-low
dp_o  output  1  decimal point, active-low
an_o  output  4  digit anodes, active-low, one-hot-low when active

Behaviour:
- Reset (async, rst_i=0):
  - an_o=4'b1111, seg_o=7'h7F, dp_o=1.
  - Sync regs, captured value/state, BCD result, prescaler and digit index all cleared to 0.
  - FSM forced to IDLE.
- Input capture:
  - {state_i,value_i} passes through two register stages s1, s2.
  - The pair counts as stable when s1==s2.
  - In IDLE: if stable and s2 != captured pair, load captured pair and go to SHIFT.
  - Multi-bit mismatch is handled by the stability check; a value changing every cycle is never captured.
- Conversion FSM (sub-module bin2bcd_seq), states IDLE -> SHIFT -> DONE -> IDLE:
  - SHIFT: 8 iterations, one per clock. Each iteration first adds 3 to every BCD nibble >= 5, then shifts {bcd[11:0],bin[7:0]} left by 1.
  - DONE: one cycle; the 12-bit result and the captured state are copied to display regs.
  - Display regs change only in DONE, so partial results are never shown.
  - Latency from a stable input change to display regs: 2 (sync) + 1 (compare) + 8 + 1 = 12 clocks max.
  - Inputs changing during SHIFT/DONE are ignored until IDLE, then re-compared, so the latest stable value is always eventually shown.
  - Max value 255 -> BCD 2,5,5; hundreds nibble never exceeds 2.
- Scan:
  - Prescaler counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, the 2-bit digit index increments, wrapping 3 -> 0.
  - Index 0 = units (an_o=1110), 1 = tens (1101), 2 = hundreds (1011), 3 = state (0111).
  - Digit 3 shows state code 0-3 as a decimal glyph with dp_o=0; dp_o=1 on all other digits.
  - seg_o, dp_o and an_o are registered and update in the same clock, so there is no cross-digit ghost cycle.
  - After reset, the first scan tick (REFRESH_DIV clocks) enables digit 0; before that an_o stays 1111.
- Glyphs (active-low {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, blank=1111111.

Optional Feature:
SEG7_LEADING_ZERO_BLANK_EN
- Defined: the hundreds digit is blank when it is 0. The tens digit is blank when hundreds and tens are both 0. Units and the state digit are never blanked. Anodes still scan during blanking (seg_o=7F).
- Undefined: all three value digits always show their glyph, including leading zeros.

Decomposition:
- Package seg7_pkg holds:
  - glyph constants for 0-9 and BLANK;
  - conversion FSM state encoding (IDLE/SHIFT/DONE);
  - digit-index constants DIG_UNITS/TENS/HUND/STATE;
  - anode patterns per index.
- Sub-module bin2bcd_seq: start/busy/done handshake, 8-bit in, 12-bit BCD out, contains the SHIFT iteration counter.
- Top level holds input sync, capture compare, display regs, prescaler, scan mux and glyph decode.

Test Plan:
- Reset, REFRESH_DIV=4: during rst_i=0 -> an_o=1111, seg_o=7F, dp_o=1; 4 clocks after release -> an_o=1110, seg_o=1000000 ('0').
- value_i=255, state_i=3 held -> within 12 clocks the scan shows 1110:'5', 1101:'5', 1011:'2', 0111:'3' with dp_o=0 only on 0111.
- value_i toggles every clock for 6 clocks, then holds 100 -> the display only ever shows 000 then 100, never an intermediate value.
- value_i=17, then 200 applied 4 clocks into SHIFT -> display shows 017, then within 12 clocks of IDLE shows 200.
- value_i=7, state 1, macro defined -> hundreds and tens slots seg_o=7F, units '7', state '1'; macro undefined -> '0','0','7','1'.
- rst_i asserted for 1 clock mid-SHIFT -> outputs return to reset values immediately; after release, the still-present value_i converts from scratch and is displayed correctly.
